// File: rtl/vga_sprite_render.sv
// Purpose: VGA raster timing generator that draws one red and one green BOX x BOX sprite at CPU coordinates.
// Latency: HS/VS/DE/RGB registered one pixel behind the counters; FRAME_TICK one CLK after the latch edge.
// Backpressure: none; free-running raster, coordinates sampled once per frame at the end of the active area.
module vga_sprite_render #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int BOX      = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] VGA_X_R,
  input  logic [31:0] VGA_Y_R,
  input  logic [31:0] VGA_X_G,
  input  logic [31:0] VGA_Y_G,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_DE,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  output logic        FRAME_TICK
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_BEG     = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VS_BEG     = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [32:0]   BOX33      = 33'(BOX);

  logic [DW-1:0] r_div_cnt;
  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic [31:0]   r_xr, r_yr, r_xg, r_yg;
  logic          r_hs, r_vs, r_de, r_tick;
  logic [3:0]    r_r, r_g, r_b;

  logic          w_pix_en, w_h_wrap, w_v_wrap, w_latch;
  logic          w_active, w_hs_n, w_vs_n, w_border, w_hit_r, w_hit_g;
  logic [32:0]   w_h33, w_v33;
  logic [3:0]    w_r, w_g, w_b;

  // Sums are taken at 33 bits so a coordinate near 2^32 stays off-screen instead of wrapping to 0.
  function automatic logic in_box(input logic [32:0] pos, input logic [31:0] org);
    return ({1'b0, org} <= pos) && (pos < ({1'b0, org} + BOX33));
  endfunction

  assign w_pix_en = (r_div_cnt == DIV_LAST);
  assign w_h_wrap = (r_h_cnt == H_LAST);
  assign w_v_wrap = (r_v_cnt == V_LAST);
  assign w_latch  = w_pix_en && w_h_wrap && (r_v_cnt == V_ACT_LAST);

  assign w_active = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_hs_n   = !((r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END));
  assign w_vs_n   = !((r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END));
  assign w_border = (r_h_cnt == '0) || (r_h_cnt == H_ACT_LAST) ||
                    (r_v_cnt == '0) || (r_v_cnt == V_ACT_LAST);

  assign w_h33   = 33'(r_h_cnt);
  assign w_v33   = 33'(r_v_cnt);
  assign w_hit_r = in_box(w_h33, r_xr) && in_box(w_v33, r_yr);
  assign w_hit_g = in_box(w_h33, r_xg) && in_box(w_v33, r_yg);

  // Sprites beyond the right/bottom edge are clipped here by the active-area gate.
  assign w_r = (w_active && w_hit_r)  ? 4'hF : 4'h0;
  assign w_g = (w_active && w_hit_g)  ? 4'hF : 4'h0;
  assign w_b = (w_active && w_border) ? 4'h3 : 4'h0;

  // Pixel-enable divider: one pixel every CLK_DIV system clocks.
  always_ff @(posedge CLK) begin
    if (RST)           r_div_cnt <= '0;
    else if (w_pix_en) r_div_cnt <= '0;
    else               r_div_cnt <= r_div_cnt + 1'b1;
  end

  // Raster counters; h and v wrap on the same pixel at the bottom-right corner.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_pix_en) begin
      if (w_h_wrap) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end
    end
  end

  // Shadow coordinates: all-ones after reset hides both sprites until the first latch.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_xr <= '1;
      r_yr <= '1;
      r_xg <= '1;
      r_yg <= '1;
    end else if (w_latch) begin
      r_xr <= VGA_X_R;
      r_yr <= VGA_Y_R;
      r_xg <= VGA_X_G;
      r_yg <= VGA_Y_G;
    end
  end

  // Frame tick is a single CLK pulse, not stretched to a full pixel.
  always_ff @(posedge CLK) begin
    if (RST) r_tick <= 1'b0;
    else     r_tick <= w_latch;
  end

  // Output stage: sync, DE and colour share one register so they stay aligned.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hs <= 1'b1;
      r_vs <= 1'b1;
      r_de <= 1'b0;
      r_r  <= 4'h0;
      r_g  <= 4'h0;
      r_b  <= 4'h0;
    end else if (w_pix_en) begin
      r_hs <= w_hs_n;
      r_vs <= w_vs_n;
      r_de <= w_active;
      r_r  <= w_r;
      r_g  <= w_g;
      r_b  <= w_b;
    end
  end

  assign VGA_HS     = r_hs;
  assign VGA_VS     = r_vs;
  assign VGA_DE     = r_de;
  assign VGA_R      = r_r;
  assign VGA_G      = r_g;
  assign VGA_B      = r_b;
  assign FRAME_TICK = r_tick;

endmodule

// File: tb/tb_vga_sprite_render.sv
// Bench for vga_sprite_render with a shrunken raster so full frames fit in a short run.
// A pixel-index reference model checks every CLK; probe tables and sequences cover corners.
module tb_vga_sprite_render;

  localparam int D   = 2;
  localparam int HA  = 32, HF = 2, HSY = 4, HB = 2;
  localparam int VA  = 24, VF = 2, VSY = 2, VB = 2;
  localparam int BOX = 4;
  localparam int HT  = HA + HF + HSY + HB;   // 40
  localparam int VT  = VA + VF + VSY + VB;   // 30
  localparam int FRAME_CLK = HT * VT * D;    // 2400

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] x_r = 32'd1000, y_r = 32'd1000, x_g = 32'd1000, y_g = 32'd1000;
  logic        VGA_HS, VGA_VS, VGA_DE, FRAME_TICK;
  logic [3:0]  VGA_R, VGA_G, VGA_B;

  int tests = 0;
  int fails = 0;

  vga_sprite_render #(
    .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .BOX(BOX)
  ) dut (
    .CLK(clk), .RST(rst),
    .VGA_X_R(x_r), .VGA_Y_R(y_r), .VGA_X_G(x_g), .VGA_Y_G(y_g),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_DE(VGA_DE),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .FRAME_TICK(FRAME_TICK)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_xr = '1, m_yr = '1, m_xg = '1, m_yg = '1;
  logic        e_hs = 1'b1, e_vs = 1'b1, e_de = 1'b0, e_tick = 1'b0;
  logic [3:0]  e_r = 4'h0, e_g = 4'h0, e_b = 4'h0;
  int          k = 0, m_n = 0, m_x = 0, m_y = 0;
  logic [3:0]  cap_r [VA][HA];
  logic [3:0]  cap_g [VA][HA];
  logic [3:0]  cap_b [VA][HA];

  function automatic bit in_box(input int p, input logic [31:0] org);
    longint o;
    o = longint'({32'd0, org});
    return (longint'(p) >= o) && (longint'(p) < o + BOX);
  endfunction

  // Pixel n since reset is shown after CLK edge (n+1)*D; its raster position is plain division.
  initial forever begin
    @(posedge clk);
    #1;
    if (rst) begin
      k = 0;
      m_xr = '1; m_yr = '1; m_xg = '1; m_yg = '1;
      e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_tick = 1'b0;
      e_r = 4'h0; e_g = 4'h0; e_b = 4'h0;
    end else begin
      k++;
      e_tick = 1'b0;
      if (k % D == 0) begin
        m_n  = k / D - 1;
        m_x  = m_n % HT;
        m_y  = (m_n / HT) % VT;
        e_de = (m_x < HA) && (m_y < VA);
        e_hs = !(m_x >= HA + HF && m_x < HA + HF + HSY);
        e_vs = !(m_y >= VA + VF && m_y < VA + VF + VSY);
        e_r  = (e_de && in_box(m_x, m_xr) && in_box(m_y, m_yr)) ? 4'hF : 4'h0;
        e_g  = (e_de && in_box(m_x, m_xg) && in_box(m_y, m_yg)) ? 4'hF : 4'h0;
        e_b  = (e_de && (m_x == 0 || m_x == HA - 1 || m_y == 0 || m_y == VA - 1)) ? 4'h3 : 4'h0;
        if (e_de) begin
          cap_r[m_y][m_x] = VGA_R;
          cap_g[m_y][m_x] = VGA_G;
          cap_b[m_y][m_x] = VGA_B;
        end
        if (m_x == HT - 1 && m_y == VA - 1) begin
          m_xr = x_r; m_yr = y_r; m_xg = x_g; m_yg = y_g;
          e_tick = 1'b1;
        end
      end
    end
    tests++;
    if ({VGA_HS, VGA_VS, VGA_DE, VGA_R, VGA_G, VGA_B, FRAME_TICK} !==
        {e_hs, e_vs, e_de, e_r, e_g, e_b, e_tick}) begin
      fails++;
      $display("FAIL pixel_model k=%0d (x=%0d y=%0d): got hs=%b vs=%b de=%b r=%h g=%h b=%h tick=%b, want hs=%b vs=%b de=%b r=%h g=%h b=%h tick=%b",
               k, m_x, m_y, VGA_HS, VGA_VS, VGA_DE, VGA_R, VGA_G, VGA_B, FRAME_TICK,
               e_hs, e_vs, e_de, e_r, e_g, e_b, e_tick);
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input longint got, input longint want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic wait_tick();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < FRAME_CLK + 50; i++) begin
      @(posedge clk);
      #1;
      if (FRAME_TICK === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL tick_timeout: got no FRAME_TICK, want one within %0d cycles", FRAME_CLK + 50);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return VGA_HS;
      1:       return VGA_VS;
      default: return FRAME_TICK;
    endcase
  endfunction

  // Cycles until the selected signal reads val; bounded, an expired bound shows up as a wrong count.
  task automatic wait_level(input int which, input logic val, output int cyc);
    cyc = 0;
    while (sig(which) !== val && cyc < 3 * FRAME_CLK) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  function automatic int count_red();
    int c;
    c = 0;
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++)
        if (cap_r[y][x] == 4'hF) c++;
    return c;
  endfunction

  function automatic logic [31:0] rnd_coord(input int lim);
    if ($urandom_range(0, 7) == 0) return $urandom();
    return 32'($urandom_range(0, lim + 4));
  endfunction

  typedef struct {
    logic [31:0] xr, yr, xg, yg;
    int          px, py;
    logic [3:0]  er, eg, eb;
    int          rcnt;
  } vec_t;

  localparam int NV = 24;
  vec_t vec [NV];

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int c, c2;

    // probe table: {xr, yr, xg, yg, px, py, R, G, B, red pixels in frame}
    vec[0]  = '{32'd10, 32'd5, 32'd1000, 32'd5, 10, 5,  4'hF, 4'h0, 4'h0, 16};
    vec[1]  = '{32'd10, 32'd5, 32'd1000, 32'd5, 13, 8,  4'hF, 4'h0, 4'h0, 16};
    vec[2]  = '{32'd10, 32'd5, 32'd1000, 32'd5, 9,  5,  4'h0, 4'h0, 4'h0, 16};
    vec[3]  = '{32'd10, 32'd5, 32'd1000, 32'd5, 14, 8,  4'h0, 4'h0, 4'h0, 16};
    vec[4]  = '{32'd10, 32'd5, 32'd1000, 32'd5, 10, 9,  4'h0, 4'h0, 4'h0, 16};
    vec[5]  = '{32'd10, 32'd5, 32'd1000, 32'd5, 0,  0,  4'h0, 4'h0, 4'h3, 16};
    vec[6]  = '{32'd10, 32'd5, 32'd1000, 32'd5, 31, 12, 4'h0, 4'h0, 4'h3, 16};
    vec[7]  = '{32'd10, 32'd5, 32'd1000, 32'd5, 15, 23, 4'h0, 4'h0, 4'h3, 16};
    vec[8]  = '{32'd12, 32'd12, 32'd14, 32'd14, 15, 15, 4'hF, 4'hF, 4'h0, 16};
    vec[9]  = '{32'd12, 32'd12, 32'd14, 32'd14, 13, 13, 4'hF, 4'h0, 4'h0, 16};
    vec[10] = '{32'd12, 32'd12, 32'd14, 32'd14, 17, 17, 4'h0, 4'hF, 4'h0, 16};
    vec[11] = '{32'd12, 32'd12, 32'd14, 32'd14, 11, 12, 4'h0, 4'h0, 4'h0, 16};
    vec[12] = '{32'd12, 32'd12, 32'd14, 32'd14, 18, 17, 4'h0, 4'h0, 4'h0, 16};
    vec[13] = '{32'hFFFFFFFE, 32'd0, 32'd30, 32'd10, 30, 10, 4'h0, 4'hF, 4'h0, 0};
    vec[14] = '{32'hFFFFFFFE, 32'd0, 32'd30, 32'd10, 31, 10, 4'h0, 4'hF, 4'h3, 0};
    vec[15] = '{32'hFFFFFFFE, 32'd0, 32'd30, 32'd10, 29, 10, 4'h0, 4'h0, 4'h0, 0};
    vec[16] = '{32'hFFFFFFFE, 32'd0, 32'd30, 32'd10, 0,  0,  4'h0, 4'h0, 4'h3, 0};
    vec[17] = '{32'hFFFFFFFE, 32'd0, 32'd30, 32'd10, 1,  1,  4'h0, 4'h0, 4'h0, 0};
    vec[18] = '{32'hFFFFFFFE, 32'd0, 32'd30, 32'd10, 31, 13, 4'h0, 4'hF, 4'h3, 0};
    vec[19] = '{32'hFFFFFFFE, 32'd0, 32'd30, 32'd10, 31, 14, 4'h0, 4'h0, 4'h3, 0};
    vec[20] = '{32'd0, 32'd22, 32'd32, 32'd5, 0,  23, 4'hF, 4'h0, 4'h3, 8};
    vec[21] = '{32'd0, 32'd22, 32'd32, 32'd5, 3,  22, 4'hF, 4'h0, 4'h0, 8};
    vec[22] = '{32'd0, 32'd22, 32'd32, 32'd5, 4,  22, 4'h0, 4'h0, 4'h0, 8};
    vec[23] = '{32'd0, 32'd22, 32'd32, 32'd5, 31, 5,  4'h0, 4'h0, 4'h3, 8};

    // reset held for three edges
    repeat (3) @(negedge clk);
    check("reset_hs", VGA_HS, 1);
    check("reset_vs", VGA_VS, 1);
    check("reset_de", VGA_DE, 0);
    check("reset_rgb", {VGA_R, VGA_G, VGA_B}, 0);
    check("reset_tick", FRAME_TICK, 0);
    x_r = 32'd10; y_r = 32'd5; x_g = 32'd1000; y_g = 32'd5;
    rst = 1'b0;
    repeat (D) @(posedge clk);
    #1;
    check("first_pixel_de", VGA_DE, 1);
    check("first_pixel_b", VGA_B, 3);
    check("first_pixel_r", VGA_R, 0);

    // sync and frame periods
    wait_level(0, 1'b0, c);
    wait_level(0, 1'b1, c);
    wait_level(0, 1'b0, c2);
    check("hs_low_clk", c, HSY * D);
    check("line_clk", c + c2, HT * D);
    wait_level(1, 1'b0, c);
    wait_level(1, 1'b1, c);
    wait_level(1, 1'b0, c2);
    check("vs_low_clk", c, VSY * HT * D);
    check("vs_period_clk", c + c2, FRAME_CLK);
    wait_level(2, 1'b1, c);
    wait_level(2, 1'b0, c);
    wait_level(2, 1'b1, c2);
    check("tick_width_clk", c, 1);
    check("tick_period_clk", c + c2, FRAME_CLK);

    // probe table
    for (int i = 0; i < NV; i++) begin
      if (i == 0 || vec[i].xr != vec[i-1].xr || vec[i].yr != vec[i-1].yr ||
          vec[i].xg != vec[i-1].xg || vec[i].yg != vec[i-1].yg) begin
        @(negedge clk);
        x_r = vec[i].xr; y_r = vec[i].yr; x_g = vec[i].xg; y_g = vec[i].yg;
        wait_tick();
        wait_tick();
        check($sformatf("red_count_v%0d", i), count_red(), vec[i].rcnt);
      end
      check($sformatf("probe_v%0d_r(%0d,%0d)", i, vec[i].px, vec[i].py), cap_r[vec[i].py][vec[i].px], vec[i].er);
      check($sformatf("probe_v%0d_g(%0d,%0d)", i, vec[i].px, vec[i].py), cap_g[vec[i].py][vec[i].px], vec[i].eg);
      check($sformatf("probe_v%0d_b(%0d,%0d)", i, vec[i].px, vec[i].py), cap_b[vec[i].py][vec[i].px], vec[i].eb);
    end

    // tear-free update: move the sprite mid-frame, above its rows
    @(negedge clk);
    x_r = 32'd10; y_r = 32'd14; x_g = 32'd1000; y_g = 32'd0;
    wait_tick();
    repeat ((VT - VA + 8) * HT * D) @(negedge clk);
    x_r = 32'd20;
    wait_tick();
    check("tear_old_pos", cap_r[14][10], 4'hF);
    check("tear_new_absent", cap_r[14][20], 4'h0);
    wait_tick();
    check("tear_new_pos", cap_r[14][20], 4'hF);
    check("tear_old_gone", cap_r[14][10], 4'h0);

    // mid-frame reset for one edge
    repeat ((VT - VA + 15) * HT * D) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_hs", VGA_HS, 1);
    check("midrst_de", VGA_DE, 0);
    check("midrst_rgb", {VGA_R, VGA_G, VGA_B}, 0);
    rst = 1'b0;
    repeat (D) @(posedge clk);
    #1;
    check("midrst_restart_de", VGA_DE, 1);
    check("midrst_restart_b", VGA_B, 3);
    wait_tick();
    check("midrst_hidden_red", count_red(), 0);
    wait_tick();
    check("midrst_relatched_red", count_red(), BOX * BOX);

    // randomized coordinates changing at arbitrary points, checked by the pixel model
    for (int j = 0; j < 24; j++) begin
      repeat ($urandom_range(100, 700)) @(negedge clk);
      x_r = rnd_coord(HA); y_r = rnd_coord(VA);
      x_g = rnd_coord(HA); y_g = rnd_coord(VA);
    end
    repeat (FRAME_CLK) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
